// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle 32/32 radix-2 restoring divider.
package div_unit_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RESULT_W = 2 * DATA_W;
  localparam int unsigned SHIFT_W  = 2 * DATA_W + 1;
  localparam int unsigned CNT_W    = 6;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [CNT_W-1:0] DIV_CYCLES = 6'd32;

endpackage

// File: rtl/div_unit_if.sv
// EX-side request/response bundle for div_unit.
// DIV_ZERO_FLAG_EN adds the div_zero_o response signal.
interface div_unit_if;
  import div_unit_pkg::*;

  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [RESULT_W-1:0] result_o;
  logic                ready_o;

`ifdef DIV_ZERO_FLAG_EN
  logic                div_zero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, div_zero_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, div_zero_o
  );
`else
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
`endif

endinterface

// File: rtl/div_unit_neg_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module div_unit_neg_abs
  import div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic              negate,
  output logic [DATA_W-1:0] result_c
);

  assign result_c = negate ? DATA_W'((~value) + DATA_W'(1)) : value;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32/32 radix-2 restoring divider for DIV/DIVU, result = {remainder, quotient}.
// Define DIV_ZERO_FLAG_EN to add the div_zero_o flag.
module div_unit
  import div_unit_pkg::*;
(
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  div_state_e           state;
  logic [CNT_W-1:0]     cnt;
  logic [SHIFT_W-1:0]   dividend;
  logic [DATA_W-1:0]    divisor;
  logic                 sgn;
  logic                 sign1;
  logic                 sign2;
  logic [RESULT_W-1:0]  result;
  logic                 ready;

  logic [DATA_W-1:0]    abs1_c;
  logic [DATA_W-1:0]    abs2_c;
  logic [DATA_W-1:0]    quot_c;
  logic [DATA_W-1:0]    rem_c;
  logic [DATA_W:0]      diff_c;
  logic                 go_c;

  // Magnitudes are taken from the live operands; they are only used in the FREE start cycle.
  div_unit_neg_abs u_abs1 (
    .value    (bus.opdata1_i),
    .negate   (bus.signed_div_i & bus.opdata1_i[DATA_W-1]),
    .result_c (abs1_c)
  );

  div_unit_neg_abs u_abs2 (
    .value    (bus.opdata2_i),
    .negate   (bus.signed_div_i & bus.opdata2_i[DATA_W-1]),
    .result_c (abs2_c)
  );

  div_unit_neg_abs u_quot (
    .value    (dividend[DATA_W-1:0]),
    .negate   (sgn & (sign1 ^ sign2)),
    .result_c (quot_c)
  );

  div_unit_neg_abs u_rem (
    .value    (dividend[SHIFT_W-1:DATA_W+1]),
    .negate   (sgn & sign1),
    .result_c (rem_c)
  );

  assign diff_c = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
  assign go_c   = (bus.start_i == DIV_START) && !bus.annul_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      sgn      <= 1'b0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      result   <= '0;
      ready    <= DIV_RESULT_NOT_READY;
    end else if (bus.annul_i && state != DIV_FREE) begin
      state  <= DIV_FREE;
      cnt    <= '0;
      result <= '0;
      ready  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          if (go_c) begin
            if (bus.opdata2_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              dividend <= {{DATA_W{1'b0}}, abs1_c, 1'b0};
              divisor  <= abs2_c;
              sgn      <= bus.signed_div_i;
              sign1    <= bus.opdata1_i[DATA_W-1];
              sign2    <= bus.opdata2_i[DATA_W-1];
              cnt      <= '0;
              state    <= DIV_ON;
            end
          end
        end
        DIV_BYZERO: begin
          result <= '0;
          ready  <= DIV_RESULT_READY;
          state  <= DIV_END;
        end
        DIV_ON: begin
          if (cnt != DIV_CYCLES) begin
            // Restoring step: keep the partial remainder only when the subtract did not borrow.
            if (diff_c[DATA_W]) begin
              dividend <= {dividend[SHIFT_W-2:0], 1'b0};
            end else begin
              dividend <= {diff_c[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
            end
            cnt <= cnt + CNT_W'(1);
          end else begin
            result <= {rem_c, quot_c};
            ready  <= DIV_RESULT_READY;
            state  <= DIV_END;
          end
        end
        DIV_END: begin
          if (bus.start_i == DIV_STOP) begin
            state  <= DIV_FREE;
            result <= '0;
            ready  <= DIV_RESULT_NOT_READY;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

`ifdef DIV_ZERO_FLAG_EN
  logic div_zero;

  // Raised alongside ready for a zero divisor, held until the result is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_zero <= 1'b0;
    end else if (bus.annul_i) begin
      div_zero <= 1'b0;
    end else if (state == DIV_BYZERO) begin
      div_zero <= 1'b1;
    end else if (state == DIV_END && bus.start_i == DIV_STOP) begin
      div_zero <= 1'b0;
    end
  end

  assign bus.div_zero_o = div_zero;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divides against an arithmetic model.
// Define DIV_ZERO_FLAG_EN to also check div_zero_o.
module tb_div_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  div_unit_if dif ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, with the zero divisor and the signed overflow pinned.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  task automatic wait_ready(output int edges);
    edges = 0;
    while (edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (dif.ready_o) break;
    end
  endtask

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
    int          edges;
    logic [63:0] exp;
    int          exp_lat;
    exp     = model(s, a, b);
    exp_lat = (b == 32'd0) ? 2 : 34;
    @(negedge clk);
    dif.signed_div_i = s;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.annul_i      = 1'b0;
    dif.start_i      = 1'b1;
    wait_ready(edges);
    chk({tag, "_lat"}, 64'(edges), 64'(exp_lat));
    chk({tag, "_res"}, dif.result_o, exp);
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, "_dz"}, 64'(dif.div_zero_o), 64'(b == 32'd0));
`endif
    // Operands may change while the result is held; it must not move.
    dif.opdata1_i    = $urandom;
    dif.opdata2_i    = $urandom;
    dif.signed_div_i = ~s;
    @(posedge clk);
    #1;
    chk({tag, "_hold_rdy"}, 64'(dif.ready_o), 64'd1);
    chk({tag, "_hold_res"}, dif.result_o, exp);
    dif.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop_rdy"}, 64'(dif.ready_o), 64'd0);
    chk({tag, "_drop_res"}, dif.result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk({tag, "_drop_dz"}, 64'(dif.div_zero_o), 64'd0);
`endif
  endtask

  initial begin
    int          edges;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    n_chk = 0;
    n_bad = 0;
    rst              = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd0;
    dif.opdata2_i    = 32'd0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(dif.ready_o), 64'd0);
    chk("rst_res", dif.result_o, 64'd0);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    do_div(1'b0, 32'd1234, 32'd0, "divu_zero");
    do_div(1'b1, 32'hFFFF_FF00, 32'd0, "div_zero");

    // Annul in the middle of a divide, then a clean divide afterwards.
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    dif.annul_i = 1'b1;
    @(posedge clk);
    #1;
    dif.annul_i = 1'b0;
    dif.start_i = 1'b0;
    chk("annul_rdy", 64'(dif.ready_o), 64'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("annul_quiet_rdy", 64'(dif.ready_o), 64'd0);
    chk("annul_quiet_res", dif.result_o, 64'd0);
    do_div(1'b0, 32'd20, 32'd5, "after_annul");

    // Start together with annul while idle is ignored.
    @(negedge clk);
    dif.opdata1_i = 32'd50;
    dif.opdata2_i = 32'd0;
    dif.start_i   = 1'b1;
    dif.annul_i   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("start_annul_rdy", 64'(dif.ready_o), 64'd0);
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;

    // Reset during computation.
    @(negedge clk);
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd3;
    dif.start_i   = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_rdy", 64'(dif.ready_o), 64'd0);
    chk("rst_mid_res", dif.result_o, 64'd0);
    rst         = 1'b0;
    dif.start_i = 1'b0;

    // Reset while the result is being held.
    @(negedge clk);
    dif.opdata1_i = 32'd9;
    dif.opdata2_i = 32'd2;
    dif.start_i   = 1'b1;
    wait_ready(edges);
    chk("rst_end_lat", 64'(edges), 64'd34);
    chk("rst_end_pre", dif.result_o, {32'd1, 32'd4});
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_end_rdy", 64'(dif.ready_o), 64'd0);
    chk("rst_end_res", dif.result_o, 64'd0);
    rst         = 1'b0;
    dif.start_i = 1'b0;

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      do_div(s, a, b, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
